vip_window_ctrl_3x3: RTL and testbench

// Timing controller that runs beside the 3x3 8-bit window generator. Tracks the pixel

---
 rtl/vip_window_ctrl_3x3.sv | 183 ++++++++++++++++++
 tb/tb_vip_window_ctrl_3x3.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_window_ctrl_3x3.sv
// rtl/vip_window_ctrl_3x3.sv - frame/line timing, LAT-aligned window coordinates
// and geometry checking alongside the 3x3 window generator.
module vip_window_ctrl_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 11,
  parameter int RW    = 10,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          win_valid,
  output logic          frame_start,
  output logic          line_done,
  output logic          frame_done,
  output logic [CW-1:0] meas_w,
  output logic [RW-1:0] meas_h,
  output logic          size_err
);

  typedef enum logic [1:0] {IDLE, FRAME, LINE, DONE} state_t;

  state_t        state_q, state_d;
  logic          vsync_q, href_q;
  logic          seen_low_q, seen_low_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          frame_start_q, frame_start_d;
  logic          line_done_q, line_done_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] meas_w_q, meas_w_d;
  logic [RW-1:0] meas_h_q, meas_h_d;
  logic          size_err_q, size_err_d;

  logic          pv_q [LAT];
  logic          pv_d [LAT];
  logic [CW-1:0] pc_q [LAT];
  logic [CW-1:0] pc_d [LAT];
  logic [RW-1:0] pr_q [LAT];
  logic [RW-1:0] pr_d [LAT];

  logic          vs_rise, vs_fall, hr_rise, hr_fall, qual;
  logic          line_pix;
  logic [CW-1:0] pix_col, col_inc;
  logic [RW-1:0] row_inc;

  assign vs_rise = per_frame_vsync & ~vsync_q;
  assign vs_fall = ~per_frame_vsync & vsync_q;
  assign hr_rise = per_frame_href & ~href_q;
  assign hr_fall = ~per_frame_href & href_q;
  assign qual    = per_frame_href & per_frame_clken;
  assign col_inc = (&col_q) ? col_q : col_q + 1'b1;
  assign row_inc = (&row_q) ? row_q : row_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    seen_low_d    = seen_low_q | ~per_frame_vsync;
    col_d         = col_q;
    row_d         = row_q;
    frame_start_d = 1'b0;
    line_done_d   = 1'b0;
    frame_done_d  = 1'b0;
    meas_w_d      = meas_w_q;
    meas_h_d      = meas_h_q;
    size_err_d    = size_err_q;
    line_pix      = 1'b0;
    pix_col       = col_q;
    case (state_q)
      IDLE: begin
        // A frame already running when we come out of reset is skipped.
        if (seen_low_q && vs_rise) begin
          frame_start_d = 1'b1;
          size_err_d    = 1'b0;
          row_d         = '0;
          state_d       = FRAME;
        end
      end
      FRAME: begin
        if (vs_fall) begin
          state_d = DONE;
        end else if (hr_rise) begin
          line_pix = qual;
          pix_col  = '0;
          col_d    = CW'(qual);
          state_d  = LINE;
        end
      end
      LINE: begin
        if (vs_fall || hr_fall) begin
          if (col_q != '0) begin
            line_done_d = 1'b1;
            meas_w_d    = col_q;
            row_d       = row_inc;
            if (col_q != CW'(IMG_W)) size_err_d = 1'b1;
          end
          if (vs_fall && !hr_fall) size_err_d = 1'b1;
          state_d = vs_fall ? DONE : FRAME;
        end else if (qual) begin
          line_pix = 1'b1;
          col_d    = col_inc;
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        meas_h_d     = row_q;
        if (row_q != RW'(IMG_H)) size_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Coordinate stages only load on a real pixel so the output holds between pixels.
  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      if (i == 0) begin
        pv_d[i] = line_pix;
        pc_d[i] = line_pix ? pix_col : pc_q[i];
        pr_d[i] = line_pix ? row_q : pr_q[i];
      end else begin
        pv_d[i] = pv_q[i-1];
        pc_d[i] = pv_q[i-1] ? pc_q[i-1] : pc_q[i];
        pr_d[i] = pv_q[i-1] ? pr_q[i-1] : pr_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      seen_low_q    <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      meas_w_q      <= '0;
      meas_h_q      <= '0;
      size_err_q    <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        pv_q[i] <= 1'b0;
        pc_q[i] <= '0;
        pr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      vsync_q       <= per_frame_vsync;
      href_q        <= per_frame_href;
      seen_low_q    <= seen_low_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
      line_done_q   <= line_done_d;
      frame_done_q  <= frame_done_d;
      meas_w_q      <= meas_w_d;
      meas_h_q      <= meas_h_d;
      size_err_q    <= size_err_d;
      for (int i = 0; i < LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pc_q[i] <= pc_d[i];
        pr_q[i] <= pr_d[i];
      end
    end
  end

  assign win_col     = pc_q[LAT-1];
  assign win_row     = pr_q[LAT-1];
  assign win_valid   = pv_q[LAT-1] && (win_row >= RW'(2)) && (win_col >= CW'(2));
  assign frame_start = frame_start_q;
  assign line_done   = line_done_q;
  assign frame_done  = frame_done_q;
  assign meas_w      = meas_w_q;
  assign meas_h      = meas_h_q;
  assign size_err    = size_err_q;

endmodule

// File: tb/tb_vip_window_ctrl_3x3.sv
// tb/tb_vip_window_ctrl_3x3.sv - scoreboard bench for vip_window_ctrl_3x3 with
// an 8x4 image geometry.
module tb_vip_window_ctrl_3x3;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int CW    = 11;
  localparam int RW    = 10;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [CW-1:0] win_col, meas_w;
  logic [RW-1:0] win_row, meas_h;
  logic          win_valid, frame_start, line_done, frame_done, size_err;

  vip_window_ctrl_3x3 #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
    .win_col(win_col), .win_row(win_row), .win_valid(win_valid),
    .frame_start(frame_start), .line_done(line_done), .frame_done(frame_done),
    .meas_w(meas_w), .meas_h(meas_h), .size_err(size_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int r; int c; } win_t;
  typedef struct { int v; logic err; } ev_t;

  win_t win_q[$];
  ev_t  line_q[$];
  ev_t  frame_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int win_seen = 0, fs_seen = 0, exp_fs = 0;
  int ld_cyc = 0, fd_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    win_t w;
    ev_t  e;
    if (win_valid) begin
      win_seen++;
      check("win_expected", longint'(win_q.size() != 0), 1);
      if (win_q.size() != 0) begin
        w = win_q.pop_front();
        check("win_row", win_row, w.r);
        check("win_col", win_col, w.c);
        check("win_cyc", cyc, w.cyc);
      end
    end
    if (line_done) begin
      ld_cyc = cyc;
      check("line_expected", longint'(line_q.size() != 0), 1);
      if (line_q.size() != 0) begin
        e = line_q.pop_front();
        check("meas_w", meas_w, e.v);
        check("line_err", size_err, e.err);
      end
    end
    if (frame_done) begin
      fd_cyc = cyc;
      check("frame_expected", longint'(frame_q.size() != 0), 1);
      if (frame_q.size() != 0) begin
        e = frame_q.pop_front();
        check("meas_h", meas_h, e.v);
        check("frame_err", size_err, e.err);
      end
    end
    if (frame_start) begin
      fs_seen++;
      check("fs_err_clr", size_err, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hr = 1'b0;
    ck = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wv"}, win_valid, 0);
    check({tag, "_wc"}, win_col, 0);
    check({tag, "_wr"}, win_row, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_ld"}, line_done, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_mw"}, meas_w, 0);
    check({tag, "_mh"}, meas_h, 0);
    check({tag, "_se"}, size_err, 0);
  endtask

  task automatic send_line(input int row, input int npix, input bit gaps, input bit track);
    int   c = 0;
    int   k = 0;
    win_t w;
    while (c < npix) begin
      hr = 1'b1;
      ck = gaps ? k[0] : 1'b1;
      if (ck) begin
        if (track && row >= 2 && c >= 2) begin
          w.cyc = cyc + LAT;
          w.r   = row;
          w.c   = c;
          win_q.push_back(w);
        end
        c++;
      end
      k++;
      tick();
    end
    hr = 1'b0;
    ck = 1'b0;
  endtask

  task automatic send_frame(input int w[4], input bit gaps, input bit vs_with_last);
    logic err = 1'b0;
    ev_t  e;
    vs = 1'b1;
    exp_fs++;
    idle(3);
    for (int i = 0; i < 4; i++) begin
      send_line(i, w[i], gaps, 1'b1);
      err |= (w[i] != IMG_W);
      e.v = w[i];
      e.err = err;
      line_q.push_back(e);
      if (i == 3 && vs_with_last) begin
        vs = 1'b0;
        e.v = 4;
        frame_q.push_back(e);
        idle(6);
      end else begin
        idle(2);
      end
    end
    if (!vs_with_last) begin
      vs = 1'b0;
      e.v = 4;
      e.err = err;
      frame_q.push_back(e);
      idle(6);
    end
  endtask

  initial begin
    ev_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);

    // full 8x4 frame, continuous clken
    win_seen = 0;
    send_frame('{8, 8, 8, 8}, 1'b0, 1'b0);
    check("t1_win_cnt", win_seen, 12);
    check("t1_fs", fs_seen, exp_fs);

    // 50% clken duty inside every line
    win_seen = 0;
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b0);
    check("t3_win_cnt", win_seen, 12);

    // short third line
    send_frame('{8, 8, 7, 8}, 1'b0, 1'b0);

    // reset in the middle of a frame, released with vsync still high
    vs = 1'b1;
    exp_fs++;
    idle(3);
    send_line(0, 8, 1'b0, 1'b1); e.v = 8; e.err = 1'b0; line_q.push_back(e); idle(2);
    send_line(1, 8, 1'b0, 1'b1); line_q.push_back(e); idle(2);
    hr = 1'b1; ck = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    hr = 1'b1; ck = 1'b1;
    repeat (6) tick();
    idle(2);
    send_line(3, 8, 1'b0, 1'b0);
    idle(2);
    vs = 1'b0;
    idle(4);
    check("t5_no_fs", fs_seen, exp_fs);
    win_seen = 0;
    send_frame('{8, 8, 8, 8}, 1'b0, 1'b0);
    check("t5_fs", fs_seen, exp_fs);
    check("t5_win_cnt", win_seen, 12);

    // vsync falls with href of the last line
    send_frame('{8, 8, 8, 8}, 1'b0, 1'b1);
    check("t6_consec", fd_cyc - ld_cyc, 1);

    // vsync drops mid way through line 2
    vs = 1'b1;
    exp_fs++;
    idle(3);
    send_line(0, 8, 1'b0, 1'b1);
    e.v = 8; e.err = 1'b0; line_q.push_back(e);
    idle(2);
    hr = 1'b1; ck = 1'b1;
    repeat (3) tick();
    vs = 1'b0; ck = 1'b0;
    e.v = 3; e.err = 1'b1; line_q.push_back(e);
    e.v = 2; frame_q.push_back(e);
    tick();
    idle(10);

    check("win_left", win_q.size(), 0);
    check("line_left", line_q.size(), 0);
    check("frame_left", frame_q.size(), 0);
    check("fs_total", fs_seen, exp_fs);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
